// File: rtl/ex_alu_muldiv_disp.sv
// ex_alu_muldiv_disp: EX-stage initiator for the iterative multiply/divide unit.
// Takes one decoded M-extension op and registers its operands and destination.
// It then issues the op to the mul/div unit and collects the result. The result
// is held in a one-entry writeback buffer until the writeback arbiter takes it.
// A single-cycle flush_pulse abandons whatever is in flight and returns to IDLE.
//
// Optional feature macro: E203_MULDIV_B2B_EN
//   defined   : keeps a history of the last completed op and sets mdv_o_info[8]
//               (B2B hint) when the new op pairs with it on identical operands.
//   undefined : no history storage, mdv_o_info[8] is tied to 0.
module ex_alu_muldiv_disp #(
  parameter int XLEN   = 32,
  parameter int ITAG_W = 2,
  parameter int INFO_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  // dispatch side (from ALU control)
  input  logic              disp_i_valid,
  output logic              disp_i_ready,
  input  logic [2:0]        disp_i_op,
  input  logic [XLEN-1:0]   disp_i_rs1,
  input  logic [XLEN-1:0]   disp_i_rs2,
  input  logic [4:0]        disp_i_rdidx,
  input  logic [ITAG_W-1:0] disp_i_itag,
  // request channel to the mul/div unit
  output logic              mdv_o_valid,
  input  logic              mdv_o_ready,
  output logic [XLEN-1:0]   mdv_o_rs1,
  output logic [XLEN-1:0]   mdv_o_rs2,
  output logic [INFO_W-1:0] mdv_o_info,
  // response channel from the mul/div unit
  input  logic              mdv_i_valid,
  output logic              mdv_i_ready,
  input  logic [XLEN-1:0]   mdv_i_wdat,
  // writeback side
  output logic              wbck_o_valid,
  input  logic              wbck_o_ready,
  output logic [XLEN-1:0]   wbck_o_wdat,
  output logic [4:0]        wbck_o_rdidx,
  output logic [ITAG_W-1:0] wbck_o_itag,
  // pipeline flush
  input  logic              flush_pulse
);

  // Op encodings as they arrive on disp_i_op
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WBCK  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [2:0]          r_op;
  logic [XLEN-1:0]     r_rs1;
  logic [XLEN-1:0]     r_rs2;
  logic [4:0]          r_rdidx;
  logic [ITAG_W-1:0]   r_itag;
  logic                r_b2b;
  logic [XLEN-1:0]     r_wdat;

  logic                w_disp_hsk;
  logic                w_res_hsk;
  logic                w_wbck_hsk;
  logic                w_b2b_new;
  logic [7:0]          w_op_onehot;

  // Handshakes that actually take effect; a flush in the same cycle cancels them
  assign w_disp_hsk = disp_i_valid & disp_i_ready & ~flush_pulse;
  assign w_res_hsk  = mdv_i_valid  & mdv_i_ready  & ~flush_pulse;
  assign w_wbck_hsk = wbck_o_valid & wbck_o_ready & ~flush_pulse;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and state-decoded handshake outputs; flush overrides any transition
  always_comb begin
    w_state_nxt  = r_state;
    disp_i_ready = 1'b0;
    mdv_o_valid  = 1'b0;
    mdv_i_ready  = 1'b0;
    wbck_o_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        disp_i_ready = 1'b1;
        if (disp_i_valid) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mdv_o_valid = 1'b1;
        if (mdv_o_ready) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        mdv_i_ready = 1'b1;
        if (mdv_i_valid) begin
          w_state_nxt = WBCK;
        end
      end
      WBCK: begin
        wbck_o_valid = 1'b1;
        if (wbck_o_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (flush_pulse) begin
      w_state_nxt = IDLE;
    end
  end

  // Capture the dispatched op; these stay frozen until the next dispatch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rdidx <= '0;
      r_itag  <= '0;
      r_b2b   <= 1'b0;
    end else if (w_disp_hsk) begin
      r_op    <= disp_i_op;
      r_rs1   <= disp_i_rs1;
      r_rs2   <= disp_i_rs2;
      r_rdidx <= disp_i_rdidx;
      r_itag  <= disp_i_itag;
      r_b2b   <= w_b2b_new;
    end
  end

  // One-entry writeback buffer, loaded only by an unflushed result in WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdat <= '0;
    end else if (w_res_hsk) begin
      r_wdat <= mdv_i_wdat;
    end
  end

`ifdef E203_MULDIV_B2B_EN
  logic            r_hist_vld;
  logic [2:0]      r_hist_op;
  logic [XLEN-1:0] r_hist_rs1;
  logic [XLEN-1:0] r_hist_rs2;
  logic            w_pair_match;

  // History of the last op that really wrote back; flush invalidates it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist_vld <= 1'b0;
      r_hist_op  <= '0;
      r_hist_rs1 <= '0;
      r_hist_rs2 <= '0;
    end else if (flush_pulse) begin
      r_hist_vld <= 1'b0;
    end else if (w_wbck_hsk) begin
      r_hist_vld <= 1'b1;
      r_hist_op  <= r_op;
      r_hist_rs1 <= r_rs1;
      r_hist_rs2 <= r_rs2;
    end
  end

  // Op pairs whose second half the mul/div unit can serve from its previous work
  always_comb begin
    w_pair_match = 1'b0;
    unique case (disp_i_op)
      OP_MUL:  w_pair_match = (r_hist_op == OP_MULH) || (r_hist_op == OP_MULHSU) ||
                              (r_hist_op == OP_MULHU);
      OP_REM:  w_pair_match = (r_hist_op == OP_DIV);
      OP_REMU: w_pair_match = (r_hist_op == OP_DIVU);
      default: w_pair_match = 1'b0;
    endcase
  end

  assign w_b2b_new = r_hist_vld & (disp_i_rs1 == r_hist_rs1) &
                     (disp_i_rs2 == r_hist_rs2) & w_pair_match;
`else
  assign w_b2b_new = 1'b0;
`endif

  assign w_op_onehot  = 8'd1 << r_op;

  assign mdv_o_rs1    = r_rs1;
  assign mdv_o_rs2    = r_rs2;
  assign mdv_o_info   = INFO_W'({r_b2b, w_op_onehot});

  assign wbck_o_wdat  = r_wdat;
  assign wbck_o_rdidx = r_rdidx;
  assign wbck_o_itag  = r_itag;

endmodule

// File: tb/tb_ex_alu_muldiv_disp.sv
// tb_ex_alu_muldiv_disp: randomized self-checking bench for ex_alu_muldiv_disp.
// The bench plays the dispatcher, mul/div unit and writeback arbiter. Results
// come from an arithmetic model of the M-extension ops. The B2B hint is predicted
// from a history record of the last op that actually wrote back.
module tb_ex_alu_muldiv_disp;

  localparam int XLEN   = 32;
  localparam int ITAG_W = 2;
  localparam int INFO_W = 9;

`ifdef E203_MULDIV_B2B_EN
  localparam bit B2B_ON = 1'b1;
`else
  localparam bit B2B_ON = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              disp_i_valid;
  logic              disp_i_ready;
  logic [2:0]        disp_i_op;
  logic [XLEN-1:0]   disp_i_rs1;
  logic [XLEN-1:0]   disp_i_rs2;
  logic [4:0]        disp_i_rdidx;
  logic [ITAG_W-1:0] disp_i_itag;
  logic              mdv_o_valid;
  logic              mdv_o_ready;
  logic [XLEN-1:0]   mdv_o_rs1;
  logic [XLEN-1:0]   mdv_o_rs2;
  logic [INFO_W-1:0] mdv_o_info;
  logic              mdv_i_valid;
  logic              mdv_i_ready;
  logic [XLEN-1:0]   mdv_i_wdat;
  logic              wbck_o_valid;
  logic              wbck_o_ready;
  logic [XLEN-1:0]   wbck_o_wdat;
  logic [4:0]        wbck_o_rdidx;
  logic [ITAG_W-1:0] wbck_o_itag;
  logic              flush_pulse;

  int totalCount = 0;
  int badCount   = 0;
  int hsCount    = 0;

  // model of the history record: last op that completed writeback
  bit        hv   = 1'b0;
  bit [2:0]  hop  = 3'd0;
  bit [31:0] hrs1 = 32'd0;
  bit [31:0] hrs2 = 32'd0;

  ex_alu_muldiv_disp #(.XLEN(XLEN), .ITAG_W(ITAG_W), .INFO_W(INFO_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_i_valid(disp_i_valid), .disp_i_ready(disp_i_ready), .disp_i_op(disp_i_op),
    .disp_i_rs1(disp_i_rs1), .disp_i_rs2(disp_i_rs2), .disp_i_rdidx(disp_i_rdidx),
    .disp_i_itag(disp_i_itag),
    .mdv_o_valid(mdv_o_valid), .mdv_o_ready(mdv_o_ready), .mdv_o_rs1(mdv_o_rs1),
    .mdv_o_rs2(mdv_o_rs2), .mdv_o_info(mdv_o_info),
    .mdv_i_valid(mdv_i_valid), .mdv_i_ready(mdv_i_ready), .mdv_i_wdat(mdv_i_wdat),
    .wbck_o_valid(wbck_o_valid), .wbck_o_ready(wbck_o_ready), .wbck_o_wdat(wbck_o_wdat),
    .wbck_o_rdidx(wbck_o_rdidx), .wbck_o_itag(wbck_o_itag),
    .flush_pulse(flush_pulse)
  );

  // free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // count request handshakes seen by the mul/div unit
  always @(posedge clk) begin
    if (rst_n && mdv_o_valid && mdv_o_ready) hsCount <= hsCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    totalCount++;
    if (observed !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // RISC-V M-extension arithmetic, straight from the ISA rules
  function automatic logic [31:0] mdRef(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    p  = 64'd0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // history op -> new op pairs that earn the B2B hint
  function automatic bit pairOk(input bit [2:0] prevOp, input bit [2:0] newOp);
    if (newOp == 3'd0) return (prevOp == 3'd1 || prevOp == 3'd2 || prevOp == 3'd3);
    if (newOp == 3'd6) return (prevOp == 3'd4);
    if (newOp == 3'd7) return (prevOp == 3'd5);
    return 1'b0;
  endfunction

  // One full transaction. flushMode: 0 none, 1 flush with the result in WAIT,
  // 2 flush together with the writeback acceptance in WBCK. Called at a negedge.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic [1:0] tag,
                               input int issueStall, input int respDelay,
                               input int wbStall, input int flushMode);
    logic [8:0]  expInfo;
    logic [31:0] res;
    int          hs0;
    expInfo      = 9'd0;
    expInfo[op]  = 1'b1;
    expInfo[8]   = B2B_ON && hv && (a == hrs1) && (b == hrs2) && pairOk(hop, op);
    res          = mdRef(op, a, b);

    checkOutput("idle_disp_ready", disp_i_ready, 1);
    disp_i_valid = 1'b1; disp_i_op = op; disp_i_rs1 = a; disp_i_rs2 = b;
    disp_i_rdidx = rd; disp_i_itag = tag;
    hs0 = hsCount;
    @(negedge clk);
    disp_i_valid = 1'b0; disp_i_op = 3'($urandom); disp_i_rs1 = $urandom; disp_i_rs2 = $urandom;
    checkOutput("req_valid", mdv_o_valid, 1);
    checkOutput("req_info", mdv_o_info, expInfo);
    checkOutput("req_rs1", mdv_o_rs1, a);
    checkOutput("req_rs2", mdv_o_rs2, b);
    checkOutput("busy_disp_ready", disp_i_ready, 0);

    for (int k = 0; k < issueStall; k++) begin
      @(negedge clk);
      disp_i_rs1 = $urandom;
      checkOutput("hold_valid", mdv_o_valid, 1);
      checkOutput("hold_rs1", mdv_o_rs1, a);
      checkOutput("hold_rs2", mdv_o_rs2, b);
      checkOutput("hold_info", mdv_o_info, expInfo);
    end
    mdv_o_ready = 1'b1;
    @(negedge clk);
    mdv_o_ready = 1'b0;
    checkOutput("req_hsk_count", hsCount - hs0, 1);
    checkOutput("wait_mdv_i_ready", mdv_i_ready, 1);
    checkOutput("wait_req_low", mdv_o_valid, 0);

    repeat (respDelay) @(negedge clk);
    mdv_i_valid = 1'b1;
    mdv_i_wdat  = (flushMode == 1) ? 32'h0000_DEAD : res;
    flush_pulse = (flushMode == 1);
    @(negedge clk);
    mdv_i_valid = 1'b0; flush_pulse = 1'b0; mdv_i_wdat = $urandom;
    if (flushMode == 1) begin
      checkOutput("flush_wait_no_wb", wbck_o_valid, 0);
      checkOutput("flush_wait_idle", disp_i_ready, 1);
      hv = 1'b0;
      return;
    end
    checkOutput("wb_valid", wbck_o_valid, 1);
    checkOutput("wb_wdat", wbck_o_wdat, res);
    checkOutput("wb_rdidx", wbck_o_rdidx, rd);
    checkOutput("wb_itag", wbck_o_itag, tag);
    checkOutput("wb_mdv_i_ready", mdv_i_ready, 0);

    for (int k = 0; k < wbStall; k++) begin
      if (k == 0) begin
        mdv_i_valid = 1'b1;
        mdv_i_wdat  = 32'hBAD0_BAD0;
      end
      @(negedge clk);
      mdv_i_valid = 1'b0;
      checkOutput("wbhold_valid", wbck_o_valid, 1);
      checkOutput("wbhold_wdat", wbck_o_wdat, res);
      checkOutput("wbhold_rdidx", wbck_o_rdidx, rd);
      checkOutput("wbhold_itag", wbck_o_itag, tag);
      checkOutput("wbhold_disp_ready", disp_i_ready, 0);
      checkOutput("wbhold_mdv_i_ready", mdv_i_ready, 0);
    end
    wbck_o_ready = 1'b1;
    flush_pulse  = (flushMode == 2);
    @(negedge clk);
    wbck_o_ready = 1'b0; flush_pulse = 1'b0;
    checkOutput("wb_done_valid", wbck_o_valid, 0);
    checkOutput("wb_done_idle", disp_i_ready, 1);
    if (flushMode == 2) begin
      hv = 1'b0;
    end else begin
      hv = 1'b1; hop = op; hrs1 = a; hrs2 = b;
    end
  endtask

  // Dispatch coinciding with a flush must be discarded (and history cleared)
  task automatic flushDispatch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    disp_i_valid = 1'b1; disp_i_op = op; disp_i_rs1 = a; disp_i_rs2 = b;
    flush_pulse  = 1'b1;
    @(negedge clk);
    disp_i_valid = 1'b0; flush_pulse = 1'b0;
    checkOutput("flush_disp_no_req", mdv_o_valid, 0);
    checkOutput("flush_disp_idle", disp_i_ready, 1);
    hv = 1'b0;
  endtask

  initial begin
    logic [31:0] pool [4];
    logic [31:0] a, b;
    int fm;
    pool[0] = 32'd100; pool[1] = 32'hFFFF_FFFF; pool[2] = 32'h8000_0000; pool[3] = 32'd0;

    rst_n = 1'b0; disp_i_valid = 1'b0; disp_i_op = '0; disp_i_rs1 = '0; disp_i_rs2 = '0;
    disp_i_rdidx = '0; disp_i_itag = '0; mdv_o_ready = 1'b0; mdv_i_valid = 1'b0;
    mdv_i_wdat = '0; wbck_o_ready = 1'b0; flush_pulse = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_disp_ready", disp_i_ready, 1);
    checkOutput("rst_mdv_o_valid", mdv_o_valid, 0);
    checkOutput("rst_mdv_i_ready", mdv_i_ready, 0);
    checkOutput("rst_wbck_valid", wbck_o_valid, 0);
    checkOutput("rst_wbck_wdat", wbck_o_wdat, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic MUL
    applyStimulus(3'd0, 32'd3, 32'd5, 5'd7, 2'd1, 0, 2, 0, 0);
    // MULHU then MUL same operands, result returned the cycle after request
    applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 2'd2, 0, 1, 0, 0);
    applyStimulus(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 2'd3, 0, 0, 0, 0);
    // DIV/REM with differing rs2, then DIV/REMU pair mismatch
    applyStimulus(3'd4, 32'd100, 32'd7, 5'd3, 2'd0, 0, 3, 0, 0);
    applyStimulus(3'd6, 32'd100, 32'd8, 5'd4, 2'd1, 0, 1, 0, 0);
    applyStimulus(3'd4, 32'd100, 32'd7, 5'd5, 2'd2, 0, 2, 0, 0);
    applyStimulus(3'd7, 32'd100, 32'd7, 5'd6, 2'd3, 0, 1, 0, 0);
    // flush in WAIT with result present, then same-operand MUL
    applyStimulus(3'd1, 32'd6, 32'd6, 5'd8, 2'd0, 0, 1, 0, 0);
    applyStimulus(3'd2, 32'd6, 32'd6, 5'd9, 2'd1, 0, 2, 0, 1);
    applyStimulus(3'd0, 32'd6, 32'd6, 5'd10, 2'd2, 0, 1, 0, 0);
    // writeback back-pressure and issue back-pressure
    applyStimulus(3'd5, 32'd1000, 32'd9, 5'd11, 2'd3, 0, 1, 5, 0);
    applyStimulus(3'd6, 32'd1000, 32'd9, 5'd12, 2'd0, 4, 1, 0, 0);
    // flush while the writeback is accepted, then a matching pair
    applyStimulus(3'd4, 32'd50, 32'd5, 5'd13, 2'd1, 0, 1, 0, 2);
    applyStimulus(3'd6, 32'd50, 32'd5, 5'd14, 2'd2, 0, 1, 0, 0);
    // dispatch killed by flush
    applyStimulus(3'd1, 32'd11, 32'd12, 5'd15, 2'd3, 0, 1, 0, 0);
    flushDispatch(3'd0, 32'd11, 32'd12);
    applyStimulus(3'd0, 32'd11, 32'd12, 5'd16, 2'd0, 0, 1, 0, 0);

    // randomized traffic with operand reuse to provoke B2B pairs
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0 || i == 0) begin
        a = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
        b = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
      end
      fm = $urandom_range(0, 9);
      fm = (fm == 0) ? 1 : ((fm == 1) ? 2 : 0);
      if ($urandom_range(0, 3) == 0) begin
        mdv_i_valid = 1'b1;
        mdv_i_wdat  = $urandom;
        @(negedge clk);
        mdv_i_valid = 1'b0;
        checkOutput("idle_stray_result", wbck_o_valid, 0);
      end
      applyStimulus(3'($urandom_range(0, 7)), a, b, 5'($urandom), 2'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), fm);
    end

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
